spectrum_frame_buffer: RTL
==========================

# spectrum_frame_buffer

Single-clock, double-buffered (ping-pong) spectrum bin store between the FFT magnitude stage and the VGA bar renderer. The writer fills the back bank and commits it; the bank swap happens only on a frame-sync pulse, so the renderer never shows a half-updated spectrum. An optional peak-hold array is refreshed by a sweep after every swap and decays geometrically. A post-reset clear sequence zeroes all storage.

## Interface
Parameters:
- ADDR_WIDTH, 6, log2 of bin count; depth N = 2**ADDR_WIDTH per bank
- DATA_WIDTH, 18, unsigned magnitude width
- DECAY_SHIFT, 4, peak decay per frame is peak >> DECAY_SHIFT; legal range 1..DATA_WIDTH-1
- PEAK_EN, 1, 1 = peak-hold array and sweep present; 0 = rd_peak tied to 0 and no sweep

Ports:
- vga_clk  in  1  sole clock; all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write wr_data to the back bank at wr_addr
- wr_addr  in  ADDR_WIDTH  back-bank write address
- wr_data  in  DATA_WIDTH  bin magnitude
- wr_commit  in  1  single-cycle pulse: back bank holds a complete frame
- frame_sync  in  1  single-cycle pulse at VGA vertical blank; swap opportunity
- rd_addr  in  ADDR_WIDTH  front-bank read address
- rd_data  out  DATA_WIDTH  registered front[rd_addr]
- rd_peak  out  DATA_WIDTH  registered peak[rd_addr]
- front_sel  out  1  bank currently displayed (0 = bank A)
- pending  out  1  committed back bank awaiting swap
- busy  out  1  high in CLEAR or SWEEP
- overrun  out  1  one-cycle pulse: commit lost or superseded

## Operation
- States: CLEAR, IDLE, SWEEP.
- CLEAR:
  - Entered on reset.
  - Counter c runs from 0 to N-1, one address per cycle, writing 0 to bank A[c], bank B[c] and peak[c].
  - wr_en, wr_commit and frame_sync are ignored.
  - At c = N-1, go to IDLE.
- IDLE:
  - wr_en writes bank[~front_sel][wr_addr].
  - wr_commit sets pending.
  - wr_commit while pending = 1 keeps pending = 1 and pulses overrun. The latest data wins, because writes always land in the back bank.
  - frame_sync with pending = 1 performs a swap: toggle front_sel, clear pending, go to SWEEP (or stay in IDLE if PEAK_EN = 0).
  - frame_sync with pending = 0 is a no-op.
- SWEEP:
  - Counter s runs from 0 to N-1.
  - Each cycle: peak[s] <= max(front[s], peak[s] - (peak[s] >> DECAY_SHIFT)). The subtraction cannot underflow and the result stays DATA_WIDTH wide.
  - The sweep uses its own internal read port on the front bank, so rd_data is unaffected.
  - Writes and commits continue as in IDLE.
  - frame_sync during SWEEP is ignored; pending stays set and the swap waits for the next frame_sync in IDLE.
  - At s = N-1, go to IDLE.
- Simultaneous events:
  - wr_commit and a swapping frame_sync in the same cycle: the swap proceeds, pending ends at 0, and overrun pulses (that commit is discarded).
  - wr_commit and frame_sync with pending = 0: pending becomes 1 and no swap occurs that cycle.
  - wr_en on the swap cycle writes the pre-swap back bank, which becomes the new front.

## Timing
- Reset values: rd_data = 0, rd_peak = 0, front_sel = 0, pending = 0, busy = 1, overrun = 0, state = CLEAR, all counters 0.
- Clear takes N cycles. busy falls on the edge after c = N-1 is written, so the first accepted write is in cycle N after reset release.
- Read latency is 1 cycle: rd_data reflects rd_addr and front_sel as sampled at the same edge. A read issued on the swap edge returns the old front bank.
- The swap is visible on front_sel 1 cycle after frame_sync is sampled.
- Sweep:
  - Starts on the cycle after front_sel toggles and lasts N cycles; busy is high throughout.
  - rd_peak for an address returns the new value from the cycle after that address is swept.
- Asserting rst_n low mid-sweep or mid-clear aborts immediately. A full CLEAR follows release.
- overrun is exactly one cycle per lost commit.

## Test plan
- **Reset/clear:** release rst_n, N = 64.
  - busy stays high for 64 cycles.
  - rd_data = rd_peak = 0 at every address.
  - A wr_en in cycle 10 is ignored.
- **Basic swap:** write back[i] = i+1 for all i, then commit, then frame_sync.
  - front_sel goes 0 -> 1 one cycle after sync; pending goes 1 -> 0.
  - A read at addr 5 returns 6 with 1-cycle latency.
- **No commit:** frame_sync with pending = 0 leaves front_sel unchanged and rd_data unchanged.
- **Double commit:** commit twice before sync.
  - overrun pulses once.
  - After sync the displayed data is the second write set.
- **Peak decay:** DECAY_SHIFT = 4; frame 1 has bin 3 = 1600, then frames of zeros are swapped in.
  - peak[3] reads 1600, then 1500, then 1407 after successive sweeps.
  - A frame with bin 3 = 2000 sets peak[3] to 2000.
- **Collisions:**
  - frame_sync during SWEEP defers the swap to the next sync.
  - commit coincident with a swap leaves pending = 0 and pulses overrun.
  - rst_n low mid-sweep restarts CLEAR.

Source files
------------

// File: rtl/spectrum_frame_buffer.sv
// spectrum_frame_buffer: ping-pong spectrum bin store with frame-sync bank swap and decaying peak hold
module spectrum_frame_buffer #(
    parameter int ADDR_WIDTH  = 6,
    parameter int DATA_WIDTH  = 18,
    parameter int DECAY_SHIFT = 4,
    parameter int PEAK_EN     = 1
) (
    input  logic                  vga_clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_commit,
    input  logic                  frame_sync,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] rd_peak,
    output logic                  front_sel,
    output logic                  pending,
    output logic                  busy,
    output logic                  overrun
);
    localparam int N = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST = '1;
    localparam logic [1:0] CLEAR = 2'd0;
    localparam logic [1:0] IDLE  = 2'd1;
    localparam logic [1:0] SWEEP = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  front_sel_q, front_sel_d;
    logic                  pending_q, pending_d;
    logic                  overrun_q, overrun_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [DATA_WIDTH-1:0] rd_peak_q, rd_peak_d;
    logic [DATA_WIDTH-1:0] mem_a [N];
    logic [DATA_WIDTH-1:0] mem_b [N];
    logic [DATA_WIDTH-1:0] mem_p [N];
    logic                  clearing, sweeping, swap, we_a, we_b, we_p;
    logic [ADDR_WIDTH-1:0] wa;
    logic [DATA_WIDTH-1:0] wd, sw_front, sw_peak, sw_decay, pd;

    // Control, write-port steering and the sweep's private front-bank read
    always_comb begin
        clearing    = state_q == CLEAR;
        sweeping    = state_q == SWEEP;
        swap        = state_q == IDLE && frame_sync && pending_q;
        wa          = clearing ? cnt_q : wr_addr;
        wd          = clearing ? '0 : wr_data;
        we_a        = clearing || (wr_en && front_sel_q);
        we_b        = clearing || (wr_en && !front_sel_q);
        sw_front    = front_sel_q ? mem_b[cnt_q] : mem_a[cnt_q];
        sw_peak     = mem_p[cnt_q];
        sw_decay    = sw_peak - (sw_peak >> DECAY_SHIFT);
        pd          = clearing ? '0 : (sw_front > sw_decay ? sw_front : sw_decay);
        we_p        = (PEAK_EN != 0) && (clearing || sweeping);
        pending_d   = !clearing && !swap && (pending_q || wr_commit);
        overrun_d   = !clearing && wr_commit && pending_q;
        front_sel_d = front_sel_q ^ swap;
        cnt_d       = (clearing || sweeping) ? cnt_q + ADDR_WIDTH'(1) : '0;
        state_d     = (clearing || sweeping) ? (cnt_q == LAST ? IDLE : state_q)
                                             : (swap && PEAK_EN != 0 ? SWEEP : IDLE);
        rd_data_d   = front_sel_q ? mem_b[rd_addr] : mem_a[rd_addr];
        rd_peak_d   = PEAK_EN != 0 ? mem_p[rd_addr] : '0;
    end

    // State, status and registered read outputs
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CLEAR;
            cnt_q       <= '0;
            front_sel_q <= 1'b0;
            pending_q   <= 1'b0;
            overrun_q   <= 1'b0;
            rd_data_q   <= '0;
            rd_peak_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            front_sel_q <= front_sel_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            rd_data_q   <= rd_data_d;
            rd_peak_q   <= rd_peak_d;
        end
    end

    // Storage arrays; zeroed by the clear sequence rather than by reset
    always_ff @(posedge vga_clk) begin
        if (we_a) mem_a[wa] <= wd;
        if (we_b) mem_b[wa] <= wd;
        if (we_p) mem_p[cnt_q] <= pd;
    end

    assign rd_data   = rd_data_q;
    assign rd_peak   = rd_peak_q;
    assign front_sel = front_sel_q;
    assign pending   = pending_q;
    assign busy      = state_q != IDLE;
    assign overrun   = overrun_q;
endmodule
